// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared state encoding and default timing for handshake_sender
package handshake_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_SETUP_CYCLES   = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/handshake_ack_sync.sv
// rtl/handshake_ack_sync.sv - two-flop synchronizer bringing the receiver's Ack into the Clock domain
module handshake_ack_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic Async_i,
    output logic Sync_o
);

    logic meta;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            meta   <= 1'b0;
            Sync_o <= 1'b0;
        end else begin
            meta   <= Async_i;
            Sync_o <= meta;
        end
    end

endmodule

// File: rtl/handshake_sender.sv
// rtl/handshake_sender.sv - 4-phase bundled-data Req/Ack initiator; HANDSHAKE_TIMEOUT_EN adds Error_o and per-phase timeout
module handshake_sender
    import handshake_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SETUP_CYCLES   = DEFAULT_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Data_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Data_o,
    output logic             Req_o,
`ifdef HANDSHAKE_TIMEOUT_EN
    output logic             Error_o,
`endif
    input  logic             Ack_i
);

    if (SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("handshake_sender: SETUP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    // One counter serves the setup delay and, when enabled, the wait-phase timeout.
`ifdef HANDSHAKE_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
`else
    localparam int CNT_MAX = SETUP_CYCLES;
`endif
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
`ifdef HANDSHAKE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_d;
    logic             req_d, busy_d, done_d;
    logic             ack_s;
`ifdef HANDSHAKE_TIMEOUT_EN
    logic             err_d;
`endif

    handshake_ack_sync u_ack_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .Async_i (Ack_i),
        .Sync_o  (ack_s)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            Data_o  <= '0;
            Req_o   <= 1'b0;
            Busy_o  <= 1'b0;
            Done_o  <= 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
            Error_o <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Data_o  <= data_d;
            Req_o   <= req_d;
            Busy_o  <= busy_d;
            Done_o  <= done_d;
`ifdef HANDSHAKE_TIMEOUT_EN
            Error_o <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = Data_o;
        req_d   = Req_o;
        busy_d  = Busy_o;
        done_d  = 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    data_d  = Data_i;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // A stale ack from the previous transfer parks us here with the counter saturated.
                if (cnt_q == SETUP_LAST) begin
                    if (!ack_s) begin
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
`ifdef HANDSHAKE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef HANDSHAKE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_handshake_sender.sv
// tb/tb_handshake_sender.sv - scoreboard bench for handshake_sender with a behavioural receiver
`timescale 1ns/1ps
module tb_handshake_sender;

    localparam int SETUP  = 2;
    localparam int TB_TIMEOUT = 16;

    typedef struct {
        logic [7:0] data;
        int         req_lat;
        bit         is_err;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic       Start_i;
    logic [7:0] Data_i;
    logic       Busy_o;
    logic       Done_o;
    logic [7:0] Data_o;
    logic       Req_o;
    logic       Ack_i;
`ifdef HANDSHAKE_TIMEOUT_EN
    logic       Error_o;
`endif

    logic rx_ack, stale_ack;
    bit   rx_auto, rx_fixed;
    assign Ack_i = rx_ack | stale_ack;

    exp_t sb[$];
    int   n_tests, n_fail;
    int   n_done, n_err, cyc;
    int   accept_cyc, req_rise_cyc, last_done_cyc, last_gap;
    bit   req_seen, prev_busy, prev_req;

    handshake_sender #(
        .WIDTH          (8),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start_i (Start_i),
        .Data_i  (Data_i),
        .Busy_o  (Busy_o),
        .Done_o  (Done_o),
        .Data_o  (Data_o),
        .Req_o   (Req_o),
`ifdef HANDSHAKE_TIMEOUT_EN
        .Error_o (Error_o),
`endif
        .Ack_i   (Ack_i)
    );

    initial Clock = 1'b0;
    always #50 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    // Receiver: acks Req rises and releases after Req falls; odd delays never land on a clock edge.
    initial begin
        int d;
        rx_ack = 1'b0;
        forever begin
            @(posedge Req_o);
            if (rx_auto) begin
                d = rx_fixed ? 75 : 2 * int'($urandom_range(10, 200)) + 1;
                #(d);
                rx_ack = 1'b1;
                @(negedge Req_o);
                d = rx_fixed ? 111 : 2 * int'($urandom_range(10, 200)) + 1;
                #(d);
                rx_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion and checks data and timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            cyc++;
            if (!Reset) begin
                prev_busy = 1'b0;
                prev_req  = 1'b0;
                req_seen  = 1'b0;
                continue;
            end
            if (Busy_o && !prev_busy) begin
                accept_cyc = cyc;
                last_gap   = cyc - last_done_cyc;
                req_seen   = 1'b0;
                check("accept_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) check("capture_data", int'(Data_o), int'(sb[0].data));
            end else if (Busy_o && prev_busy && sb.size() > 0) begin
                check("data_stable", int'(Data_o), int'(sb[0].data));
            end
            if (Req_o && !prev_req) begin
                req_rise_cyc = cyc;
                req_seen     = 1'b1;
                check("req_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check("data_at_req", int'(Data_o), int'(sb[0].data));
                    if (sb[0].req_lat != 0)
                        check("req_latency", cyc - accept_cyc, sb[0].req_lat);
                end
            end
            if (Done_o) begin
                n_done++;
                last_done_cyc = cyc;
                check("done_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("done_not_error", int'(e.is_err), 0);
                    check("done_data", int'(Data_o), int'(e.data));
                end
                check("done_after_req", int'(req_seen), 1);
                check("busy_low_at_done", int'(Busy_o), 0);
            end
`ifdef HANDSHAKE_TIMEOUT_EN
            if (Error_o) begin
                n_err++;
                check("error_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("error_is_expected", int'(e.is_err), 1);
                end
                check("timeout_cycles", cyc - req_rise_cyc, TB_TIMEOUT);
                check("req_low_at_error", int'(Req_o), 0);
                check("busy_low_at_error", int'(Busy_o), 0);
                check("no_done_with_error", int'(Done_o), 0);
            end
`endif
            prev_busy = Busy_o;
            prev_req  = Req_o;
        end
    end

    task automatic start_xfer(input logic [7:0] d, input int lat, input bit err);
        sb.push_back('{data: d, req_lat: lat, is_err: err});
        Start_i = 1'b1;
        Data_i  = d;
        tick();
        Start_i = 1'b0;
        Data_i  = 8'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (n_done < target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(n_done >= target), 1);
    endtask

    task automatic wait_req_high(input int budget, input string name);
        int n = 0;
        while (Req_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(Req_o === 1'b1), 1);
    endtask

    task automatic wait_busy(input logic level, input int budget, input string name);
        int n = 0;
        while (Busy_o !== level && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(Busy_o === level), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] d;
        Reset = 1'b0; Start_i = 1'b0; Data_i = 8'h00;
        stale_ack = 1'b0; rx_auto = 1'b0; rx_fixed = 1'b1;
        last_done_cyc = 0;

        // Reset values
        repeat (3) @(posedge Clock);
        #1;
        check("rst_req", int'(Req_o), 0);
        check("rst_busy", int'(Busy_o), 0);
        check("rst_done", int'(Done_o), 0);
        check("rst_data", int'(Data_o), 0);
        tick();
        Reset = 1'b1;
        repeat (3) tick();

        // Nominal transfer with a second Start during REQ that must be ignored
        rx_auto = 1'b1; rx_fixed = 1'b1;
        base = n_done;
        start_xfer(8'hA5, SETUP, 1'b0);
        wait_req_high(20, "nominal_req_rise");
        Start_i = 1'b1; Data_i = 8'h3C;
        tick();
        Start_i = 1'b0;
        check("ignored_start_data", int'(Data_o), 8'hA5);
        wait_done(base + 1, 100, "nominal_done");
        repeat (10) tick();
        check("nominal_done_count", n_done - base, 1);
        check("nominal_busy_after", int'(Busy_o), 0);

        // Back-to-back with Start held high
        base = n_done;
        sb.push_back('{data: 8'h01, req_lat: SETUP, is_err: 1'b0});
        Start_i = 1'b1; Data_i = 8'h01;
        wait_busy(1'b1, 10, "b2b_first_accept");
        Data_i = 8'h02;
        sb.push_back('{data: 8'h02, req_lat: SETUP, is_err: 1'b0});
        wait_done(base + 1, 100, "b2b_first_done");
        wait_busy(1'b1, 10, "b2b_second_accept");
        Start_i = 1'b0;
        check("b2b_idle_gap", last_gap, 1);
        wait_done(base + 2, 100, "b2b_second_done");
        repeat (5) tick();
        check("b2b_done_count", n_done - base, 2);

        // Stale ack: Req must wait for the low level to cross the synchronizer
        rx_auto = 1'b0;
        base = n_done;
        stale_ack = 1'b1;
        repeat (4) tick();
        start_xfer(8'hC3, 0, 1'b0);
        repeat (6) tick();
        check("stale_req_held", int'(Req_o), 0);
        check("stale_busy", int'(Busy_o), 1);
        rx_auto = 1'b1;
        stale_ack = 1'b0;
        @(posedge Clock); #1;
        check("stale_req_e1", int'(Req_o), 0);
        @(posedge Clock); #1;
        check("stale_req_e2", int'(Req_o), 0);
        @(posedge Clock); #1;
        check("stale_req_e3", int'(Req_o), 1);
        wait_done(base + 1, 100, "stale_done");
        repeat (3) tick();

        // Reset in the middle of REQ aborts the transfer
        rx_auto = 1'b0;
        base = n_done;
        start_xfer(8'h96, SETUP, 1'b0);
        wait_req_high(20, "midrst_req_rise");
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("midrst_req", int'(Req_o), 0);
        check("midrst_busy", int'(Busy_o), 0);
        check("midrst_data", int'(Data_o), 0);
        check("midrst_done", int'(Done_o), 0);
        @(posedge Clock); #1;
        check("midrst_done2", int'(Done_o), 0);
        tick();
        Reset = 1'b1;
        sb.delete();
        repeat (5) tick();
        check("midrst_no_done", n_done - base, 0);

        // Randomized transfers with random receiver delays and spurious starts
        rx_auto = 1'b1; rx_fixed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            base = n_done;
            repeat ($urandom_range(0, 3)) tick();
            wait_busy(1'b0, 20, "rand_idle");
            d = 8'($urandom);
            start_xfer(d, SETUP, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) tick();
                if (Busy_o === 1'b1) begin
                    Start_i = 1'b1; Data_i = 8'($urandom);
                    tick();
                    Start_i = 1'b0;
                end
            end
            wait_done(base + 1, 200, "rand_done");
        end
        repeat (5) tick();

`ifdef HANDSHAKE_TIMEOUT_EN
        // Receiver never answers: timeout fires
        rx_auto = 1'b0;
        base = n_done;
        begin
            int n = 0;
            int eb = n_err;
            start_xfer(8'h5A, SETUP, 1'b1);
            while (n_err == eb && n < 60) begin
                tick();
                n++;
            end
            check("timeout_fired", n_err - eb, 1);
        end
        repeat (5) tick();
        check("timeout_no_done", n_done - base, 0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
